// File: rtl/delay_pkg.sv
// Shared sizing helpers for delay-type blocks.
package delay_pkg;

    // Ceiling log2; clog2(0) and clog2(1) both return 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width needed to hold any delay value 0..max_delay, never below 1.
    function automatic int unsigned sel_width(input int unsigned max_delay);
        int unsigned w;
        w = clog2(max_delay + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/delay_line_register_ce.sv
// Clock-enabled register with asynchronous reset and a synchronous clear
// that only affects the bits selected by CLR_MASK (others hold).
module register_ce #(
    parameter int unsigned    W        = 1,
    parameter logic [W-1:0]   CLR_MASK = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next value: clear wins over enable; masked-off bits keep their contents.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = q_q & ~CLR_MASK;
        end else if (ce) begin
            q_d = d;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/delay_line.sv
// Selectable-latency delay line: MAX_DELAY stages of data+valid, tapped at
// min(sel, MAX_DELAY), with a saturating fill counter driving 'primed'.
module delay_line
    import delay_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned MAX_DELAY = 4,
    localparam int unsigned SEL_W    = sel_width(MAX_DELAY)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  flush,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N*CHANNELS-1:0] d,
    input  logic                  d_valid,
    output logic [N*CHANNELS-1:0] q,
    output logic                  q_valid,
    output logic                  primed
);

    localparam int unsigned DW = N * CHANNELS;
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);

    // Each stage word is {valid, data}; flush clears only the valid bit.
    logic [DW:0]      stg [MAX_DELAY+1];
    logic [DW:0]      tap;
    logic [SEL_W-1:0] sel_eff;
    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    assign stg[0] = {d_valid, d};

    for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_stage
        register_ce #(
            .W        (DW + 1),
            .CLR_MASK ({1'b1, {DW{1'b0}}})
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .ce    (ce),
            .clr   (flush),
            .d     (stg[k-1]),
            .q     (stg[k])
        );
    end

    // Clamp out-of-range delay requests to the deepest stage.
    always_comb begin
        sel_eff = (sel > MAX_SEL) ? MAX_SEL : sel;
    end

    // Output tap: stage sel_eff, stage 0 being the live input.
    always_comb begin
        tap = stg[0];
        for (int unsigned i = 1; i <= MAX_DELAY; i++) begin
            if (sel_eff == SEL_W'(i)) begin
                tap = stg[i];
            end
        end
    end

    // Fill counter next value: flush clears, ce advances up to MAX_DELAY.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (ce && (cnt_q < MAX_SEL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fill counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q       = tap[DW-1:0];
    assign q_valid = tap[DW];
    assign primed  = (cnt_q >= sel_eff);

endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line (N=8, CHANNELS=2, MAX_DELAY=4): directed scenarios
// with literal expectations, then randomized traffic against a queue model.
module tb_delay_line;

    localparam int N  = 8;
    localparam int CH = 2;
    localparam int MD = 4;
    localparam int DW = N * CH;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          flush = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [DW-1:0] d = '0;
    logic          d_valid = 1'b0;
    logic [DW-1:0] q;
    logic          q_valid;
    logic          primed;

    int checks = 0;
    int failures = 0;

    delay_line #(
        .N         (N),
        .CHANNELS  (CH),
        .MAX_DELAY (MD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .flush   (flush),
        .sel     (sel),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .primed  (primed)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of accepted inputs, newest first; entry k is what was
    // presented k+1 ce-edges ago. Fill count tracks ce-edges since reset/flush.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          valid;
    } samp_t;

    samp_t hist[$];
    int    m_cnt = 0;

    initial begin
        for (int i = 0; i < MD; i++) hist.push_back('0);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < MD; i++) hist[i] = '0;
                m_cnt = 0;
            end else if (flush) begin
                for (int i = 0; i < MD; i++) hist[i].valid = 1'b0;
                m_cnt = 0;
            end else if (ce) begin
                hist.push_front(samp_t'{data: d, valid: d_valid});
                void'(hist.pop_back());
                m_cnt = (m_cnt + 1 > MD) ? MD : m_cnt + 1;
            end
        end
    end

    // Compare process: every cycle, mid-low-phase, once inputs are settled.
    initial begin
        int            se;
        logic [DW-1:0] eq;
        logic          ev;
        forever begin
            @(negedge clk);
            #2;
            se = (int'(sel) > MD) ? MD : int'(sel);
            if (se == 0) begin
                eq = d;
                ev = d_valid;
            end else begin
                eq = hist[se-1].data;
                ev = hist[se-1].valid;
            end
            check("model_q", 32'(q), 32'(eq));
            check("model_q_valid", 32'(q_valid), 32'(ev));
            check("model_primed", 32'(primed), 32'(m_cnt >= se));
        end
    end

    task automatic step(input logic c, input logic f, input logic [SW-1:0] s,
                        input logic [DW-1:0] dd, input logic dv);
        @(negedge clk);
        ce = c; flush = f; sel = s; d = dd; d_valid = dv;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ce = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
        #4 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] r;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Latency 3 through two lanes.
        do_reset();
        step(1, 0, 3, 16'h5AA5, 1);
        check("d034_c0_qv", 32'(q_valid), 0);
        check("d034_c0_q", 32'(q), 0);
        check("d034_c0_primed", 32'(primed), 0);
        step(1, 0, 3, 16'h0000, 0);
        check("d034_c1_qv", 32'(q_valid), 0);
        step(1, 0, 3, 16'h0000, 0);
        check("d034_c2_qv", 32'(q_valid), 0);
        check("d034_c2_primed", 32'(primed), 0);
        step(1, 0, 3, 16'h0000, 0);
        check("d034_c3_q", 32'(q), 32'h5AA5);
        check("d034_c3_qv", 32'(q_valid), 1);
        check("d034_c3_primed", 32'(primed), 1);
        step(1, 0, 3, 16'h0000, 0);
        check("d034_c4_qv", 32'(q_valid), 0);

        // Clock-enable gating with sel=2.
        do_reset();
        step(1, 0, 2, 16'h0011, 1);
        step(0, 0, 2, 16'h0000, 0);
        check("d035_c1_qv", 32'(q_valid), 0);
        step(1, 0, 2, 16'h0000, 0);
        check("d035_c2_qv", 32'(q_valid), 0);
        step(0, 0, 2, 16'h0000, 0);
        check("d035_c3_q", 32'(q), 32'h0011);
        check("d035_c3_qv", 32'(q_valid), 1);
        step(1, 0, 2, 16'h0000, 0);
        check("d035_c4_hold_q", 32'(q), 32'h0011);
        check("d035_c4_hold_qv", 32'(q_valid), 1);
        step(0, 0, 2, 16'h0000, 0);
        check("d035_c5_qv", 32'(q_valid), 0);

        // Out-of-range sel clamps to MAX_DELAY.
        do_reset();
        step(1, 0, 7, 16'hBEEF, 1);
        repeat (2) step(1, 0, 7, 16'h0000, 0);
        step(1, 0, 7, 16'h0000, 0);
        check("d036_c3_qv", 32'(q_valid), 0);
        check("d036_c3_primed", 32'(primed), 0);
        step(1, 0, 7, 16'h0000, 0);
        check("d036_c4_q", 32'(q), 32'hBEEF);
        check("d036_c4_qv", 32'(q_valid), 1);
        check("d036_c4_primed", 32'(primed), 1);

        // Flush with ce on cycle 2 of a 4-sample stream.
        do_reset();
        step(1, 0, 4, 16'hA001, 1);
        step(1, 0, 4, 16'hA002, 1);
        step(1, 1, 4, 16'hA003, 1);
        step(1, 0, 4, 16'hA004, 1);
        check("d037_c3_primed", 32'(primed), 0);
        check("d037_c3_qv", 32'(q_valid), 0);
        for (int i = 4; i < 7; i++) begin
            step(1, 0, 4, 16'h0000, 0);
            check("d037_flushed_qv", 32'(q_valid), 0);
        end
        step(1, 0, 4, 16'h0000, 0);
        check("d037_c7_q", 32'(q), 32'hA004);
        check("d037_c7_qv", 32'(q_valid), 1);

        // Zero delay is a combinational pass-through.
        for (int i = 0; i < 4; i++) begin
            r = DW'($urandom);
            step(0, 0, 0, r, 1'(i));
            check("d038_q", 32'(q), 32'(r));
            check("d038_qv", 32'(q_valid), 32'(i % 2));
            check("d038_primed", 32'(primed), 1);
        end

        // Asynchronous reset with a full pipeline.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 4, DW'(16'hC000 + i), 1);
        @(negedge clk);
        ce = 1'b1; flush = 1'b0; sel = 4; d = '0; d_valid = 1'b0;
        #4 rst_n = 1'b0;
        #1;
        check("d039_rst_q", 32'(q), 0);
        check("d039_rst_qv", 32'(q_valid), 0);
        check("d039_rst_primed", 32'(primed), 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 4, 16'h0000, 0);
            check("d039_post_qv", 32'(q_valid), 0);
        end

        // Randomized traffic, including occasional mid-cycle reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ce      = ($urandom % 4) != 0;
            flush   = ($urandom % 16) == 0;
            sel     = SW'($urandom_range(0, 7));
            d       = DW'($urandom);
            d_valid = 1'($urandom);
            if (($urandom % 150) == 0) begin
                #4 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
